// File: rtl/mult_pkg.sv
// Shared definitions for the multiply-accumulate stage: default widths and FSM state encoding.
package mult_pkg;

  localparam int PROD_W = 32;
  localparam int ACC_W  = 40;
  localparam int CNT_W  = 8;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/mult_acc_stage_acc_add.sv
// ACC_W-bit adder with carry-out; clamps to all-ones on carry when MULT_ACC_SAT_EN is defined.
module acc_add #(
  parameter int ACC_W = 40
) (
  input  logic [ACC_W-1:0] i_a,
  input  logic [ACC_W-1:0] i_b,
  output logic [ACC_W-1:0] o_sum,
  output logic             o_carry
);

  logic [ACC_W:0] w_full;

  assign w_full  = {1'b0, i_a} + {1'b0, i_b};
  assign o_carry = w_full[ACC_W];

`ifdef MULT_ACC_SAT_EN
  // Once clamped, any further nonzero addend carries again, so the sum stays pinned.
  assign o_sum = o_carry ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];
`else
  assign o_sum = w_full[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_acc_stage.sv
// Burst accumulator behind the 16x16 multiplier: sums products until prod_last, then holds the
// result for the consumer. Optional saturation via MULT_ACC_SAT_EN (wraps when undefined).
module mult_acc_stage
  import mult_pkg::state_t;
  import mult_pkg::ST_ACCUM;
  import mult_pkg::ST_HOLD;
#(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic              clear,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic               r_prod_ready;
  logic               r_acc_valid;

  logic [ACC_W-1:0]   w_prod_ext;
  logic [ACC_W-1:0]   w_sum;
  logic               w_carry;
  logic               w_xfer;
  logic [CNT_W-1:0]   w_cnt_nxt;

  assign w_prod_ext = ACC_W'(prod_data);
  assign w_xfer     = prod_valid & r_prod_ready;
  assign w_cnt_nxt  = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

  acc_add #(.ACC_W(ACC_W)) u_add (
    .i_a     (r_acc),
    .i_b     (w_prod_ext),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b1;
      r_acc_valid  <= 1'b0;
    end else if (clear) begin
      // Abort wins over everything, including a same-cycle product or a pending result.
      r_state      <= ST_ACCUM;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      r_prod_ready <= 1'b1;
      r_acc_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_carry;
            if (prod_last) begin
              r_state      <= ST_HOLD;
              r_prod_ready <= 1'b0;
              r_acc_valid  <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (acc_ready) begin
            r_state      <= ST_ACCUM;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_prod_ready <= 1'b1;
            r_acc_valid  <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_ACCUM;
          r_prod_ready <= 1'b1;
          r_acc_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign prod_ready = r_prod_ready;
  assign acc_valid  = r_acc_valid;
  assign acc_data   = r_acc;
  assign acc_count  = r_cnt;
  assign acc_ovf    = r_ovf;

endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed bench for mult_acc_stage; overflow expectations follow MULT_ACC_SAT_EN.
module tb_mult_acc_stage;

  logic        clk;
  logic        rst_n;
  logic        prod_valid;
  logic        prod_ready;
  logic [31:0] prod_data;
  logic        prod_last;
  logic        clear;
  logic        acc_valid;
  logic        acc_ready;
  logic [39:0] acc_data;
  logic [7:0]  acc_count;
  logic        acc_ovf;

  int n_asrt = 0;
  int n_fail = 0;

  mult_acc_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_ready (prod_ready),
    .prod_data  (prod_data),
    .prod_last  (prod_last),
    .clear      (clear),
    .acc_valid  (acc_valid),
    .acc_ready  (acc_ready),
    .acc_data   (acc_data),
    .acc_count  (acc_count),
    .acc_ovf    (acc_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {63'd0, acc_valid}, 64'd0);
    chk({tag, "_rdy"},   {63'd0, prod_ready}, 64'd1);
    chk({tag, "_data"},  {24'd0, acc_data}, 64'd0);
    chk({tag, "_cnt"},   {56'd0, acc_count}, 64'd0);
    chk({tag, "_ovf"},   {63'd0, acc_ovf}, 64'd0);
  endtask

  initial begin
    rst_n = 1'b1; prod_valid = 1'b0; prod_data = '0; prod_last = 1'b0;
    clear = 1'b0; acc_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_idle("reset");
    #20 rst_n = 1'b1;
    step();

    // basic burst 6, 15, 0x10000
    prod_valid = 1'b1; prod_data = 32'd6; step();
    prod_data = 32'd15; step();
    chk("basic_mid_data", {24'd0, acc_data}, 64'd21);
    prod_data = 32'h10000; prod_last = 1'b1; step();
    chk("basic_valid", {63'd0, acc_valid}, 64'd1);
    chk("basic_data", {24'd0, acc_data}, 64'h10015);
    chk("basic_cnt", {56'd0, acc_count}, 64'd3);
    chk("basic_ovf", {63'd0, acc_ovf}, 64'd0);
    chk("basic_rdy", {63'd0, prod_ready}, 64'd0);
    prod_valid = 1'b0; prod_last = 1'b0; acc_ready = 1'b1; step();
    chk_idle("basic_done");
    acc_ready = 1'b0;

    // backpressure: burst 1,2 then a pending product 100 held for 5 cycles
    prod_valid = 1'b1; prod_data = 32'd1; step();
    prod_data = 32'd2; prod_last = 1'b1; step();
    prod_data = 32'd100;
    for (int i = 0; i < 5; i++) begin
      chk("bp_rdy", {63'd0, prod_ready}, 64'd0);
      chk("bp_data", {24'd0, acc_data}, 64'd3);
      step();
    end
    chk("bp_valid", {63'd0, acc_valid}, 64'd1);
    acc_ready = 1'b1; step();
    chk("bp_bubble_valid", {63'd0, acc_valid}, 64'd0);
    chk("bp_bubble_rdy", {63'd0, prod_ready}, 64'd1);
    acc_ready = 1'b0; step();
    chk("bp_next_valid", {63'd0, acc_valid}, 64'd1);
    chk("bp_next_data", {24'd0, acc_data}, 64'd100);
    chk("bp_next_cnt", {56'd0, acc_count}, 64'd1);
    prod_valid = 1'b0; prod_last = 1'b0; acc_ready = 1'b1; step();
    acc_ready = 1'b0;

    // overflow: 257 x 0xFFFF_FFFF
    prod_valid = 1'b1; prod_data = 32'hFFFF_FFFF;
    for (int i = 0; i < 257; i++) begin
      prod_last = (i == 256);
      step();
      if (i == 0) chk("ovf_first_ovf", {63'd0, acc_ovf}, 64'd0);
    end
    chk("ovf_valid", {63'd0, acc_valid}, 64'd1);
`ifdef MULT_ACC_SAT_EN
    chk("ovf_data", {24'd0, acc_data}, 64'hFF_FFFF_FFFF);
`else
    chk("ovf_data", {24'd0, acc_data}, 64'h00_FFFF_FEFF);
`endif
    chk("ovf_flag", {63'd0, acc_ovf}, 64'd1);
    chk("ovf_cnt", {56'd0, acc_count}, 64'd255);
    prod_valid = 1'b0; prod_last = 1'b0; acc_ready = 1'b1; step();
    chk_idle("ovf_done");
    acc_ready = 1'b0;

    // clear collides with a last transfer of 7
    prod_valid = 1'b1; prod_data = 32'd7; prod_last = 1'b1; clear = 1'b1; step();
    chk_idle("clr_coll");
    clear = 1'b0; prod_data = 32'd2; step();
    chk("clr_next_valid", {63'd0, acc_valid}, 64'd1);
    chk("clr_next_data", {24'd0, acc_data}, 64'd2);
    chk("clr_next_cnt", {56'd0, acc_count}, 64'd1);
    // clear drops the pending result in HOLD
    prod_valid = 1'b0; clear = 1'b1; step();
    chk_idle("clr_hold");
    clear = 1'b0;

    // back-to-back single-product bursts, acc_ready tied high
    acc_ready = 1'b1; prod_valid = 1'b1; prod_last = 1'b1; prod_data = 32'd3; step();
    chk("b2b_v0", {63'd0, acc_valid}, 64'd1);
    chk("b2b_d0", {24'd0, acc_data}, 64'd3);
    prod_data = 32'd5; step();
    chk("b2b_bubble", {63'd0, acc_valid}, 64'd0);
    step();
    chk("b2b_v1", {63'd0, acc_valid}, 64'd1);
    chk("b2b_d1", {24'd0, acc_data}, 64'd5);
    chk("b2b_c1", {56'd0, acc_count}, 64'd1);
    prod_data = 32'd11; step(); step();
    chk("b2b_d2", {24'd0, acc_data}, 64'd11);
    prod_valid = 1'b0; prod_last = 1'b0; step();
    acc_ready = 1'b0;

    // async reset mid-burst after 3 products
    prod_valid = 1'b1; prod_data = 32'd9;
    step(); step(); step();
    chk("rst_pre_cnt", {56'd0, acc_count}, 64'd3);
    rst_n = 1'b0;
    #1 chk_idle("rst_mid");
    prod_valid = 1'b0;
    #10 rst_n = 1'b1;
    step();
    chk_idle("rst_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
